// File: rtl/response_router.sv
// Return path for the triple-ported memory. Each lane response is steered
// back to its originating port (1..3) through a small per-port FIFO. This
// undoes the request-side lane compaction and absorbs consumer backpressure.
module response_router #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] lane1_in,
  input  logic [1:0]       lane1_id,
  input  logic [1:0]       lane1_req_tag_in,
  input  logic             lane1_in_valid,
  input  logic [WIDTH-1:0] lane2_in,
  input  logic [1:0]       lane2_id,
  input  logic [1:0]       lane2_req_tag_in,
  input  logic             lane2_in_valid,
  input  logic [WIDTH-1:0] lane3_in,
  input  logic [1:0]       lane3_id,
  input  logic [1:0]       lane3_req_tag_in,
  input  logic             lane3_in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] port1_out,
  output logic [1:0]       port1_req_tag_out,
  output logic             port1_out_valid,
  input  logic             port1_ready,
  output logic [WIDTH-1:0] port2_out,
  output logic [1:0]       port2_req_tag_out,
  output logic             port2_out_valid,
  input  logic             port2_ready,
  output logic [WIDTH-1:0] port3_out,
  output logic [1:0]       port3_req_tag_out,
  output logic             port3_out_valid,
  input  logic             port3_ready,
  output logic             err_dup_id,
  output logic             err_bad_id
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = WIDTH + 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // Lane and port signals gathered into arrays so the logic is written once
  logic [WIDTH-1:0] lane_dat [3];
  logic [1:0]       lane_id  [3];
  logic [1:0]       lane_tag [3];
  logic [2:0]       lane_vld;
  logic [2:0]       port_rdy;

  assign lane_dat[0] = lane1_in;
  assign lane_dat[1] = lane2_in;
  assign lane_dat[2] = lane3_in;
  assign lane_id[0]  = lane1_id;
  assign lane_id[1]  = lane2_id;
  assign lane_id[2]  = lane3_id;
  assign lane_tag[0] = lane1_req_tag_in;
  assign lane_tag[1] = lane2_req_tag_in;
  assign lane_tag[2] = lane3_req_tag_in;
  assign lane_vld    = {lane3_in_valid, lane2_in_valid, lane1_in_valid};
  assign port_rdy    = {port3_ready, port2_ready, port1_ready};

  // FIFO state: pointers and counts are control; storage is not reset
  logic [AW-1:0] wr_ptr [3];
  logic [AW-1:0] rd_ptr [3];
  logic [AW:0]   count  [3];
  logic [EW-1:0] mem    [3][FIFO_DEPTH];

  logic [2:0]    lane_push;
  logic          dup_hit;
  logic          bad_hit;
  logic [2:0]    push_vld;
  logic [EW-1:0] push_ent [3];
  logic [2:0]    pop;
  logic [EW-1:0] head_ent [3];

  // Accept only when no FIFO is full; a full FIFO's same-cycle pop is ignored
  always_comb begin
    in_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      if (count[p] == FULL_CNT) in_ready = 1'b0;
    end
  end

  // Lane qualification: id 0 is dropped, and for a repeated id the lowest lane wins
  always_comb begin
    lane_push = '0;
    dup_hit   = 1'b0;
    bad_hit   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (in_ready && lane_vld[i]) begin
        if (lane_id[i] == 2'd0) begin
          bad_hit = 1'b1;
        end else begin
          lane_push[i] = 1'b1;
          for (int j = 0; j < i; j++) begin
            if (lane_vld[j] && (lane_id[j] == lane_id[i])) begin
              lane_push[i] = 1'b0;
              dup_hit      = 1'b1;
            end
          end
        end
      end
    end
  end

  // Steer each surviving lane to the FIFO named by its id (at most one per FIFO)
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      push_vld[p] = 1'b0;
      push_ent[p] = '0;
      pop[p]      = (count[p] != '0) && port_rdy[p];
      for (int i = 0; i < 3; i++) begin
        if (lane_push[i] && (lane_id[i] == 2'(p + 1))) begin
          push_vld[p] = 1'b1;
          push_ent[p] = {lane_tag[i], lane_dat[i]};
        end
      end
    end
  end

  // Pointer/count update and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 3; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
        count[p]  <= '0;
      end
      err_dup_id <= 1'b0;
      err_bad_id <= 1'b0;
    end else begin
      for (int p = 0; p < 3; p++) begin
        if (push_vld[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
        if (pop[p])      rd_ptr[p] <= rd_ptr[p] + 1'b1;
        case ({push_vld[p], pop[p]})
          2'b10:   count[p] <= count[p] + 1'b1;
          2'b01:   count[p] <= count[p] - 1'b1;
          default: count[p] <= count[p];
        endcase
      end
      if (dup_hit) err_dup_id <= 1'b1;
      if (bad_hit) err_bad_id <= 1'b1;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    for (int p = 0; p < 3; p++) begin
      if (push_vld[p]) mem[p][wr_ptr[p]] <= push_ent[p];
    end
  end

  // Head entry, forced to zero while the FIFO is empty
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      head_ent[p] = (count[p] != '0) ? mem[p][rd_ptr[p]] : '0;
    end
  end

  assign port1_out         = head_ent[0][WIDTH-1:0];
  assign port1_req_tag_out = head_ent[0][EW-1:WIDTH];
  assign port1_out_valid   = (count[0] != '0);
  assign port2_out         = head_ent[1][WIDTH-1:0];
  assign port2_req_tag_out = head_ent[1][EW-1:WIDTH];
  assign port2_out_valid   = (count[1] != '0);
  assign port3_out         = head_ent[2][WIDTH-1:0];
  assign port3_req_tag_out = head_ent[2][EW-1:WIDTH];
  assign port3_out_valid   = (count[2] != '0);

endmodule
